load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the execute ALU. Takes the ALU result as effective address,
//  plus store data and funct3, and runs one data-memory transaction over a req/gnt/rvalid bus.
//  Generates byte enables and replicated store data; returns sign/zero-extended load data to
//  writeback. One transaction in flight; the core stalls on req_ready.
// PARAMETERS
//  ADDR_WIDTH  32  width of address/dmem_addr
//  XLEN        32  data width; only 32 supported (4 byte lanes)
// PORTS
//  clk          in   1     single clock, rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  req_valid    in   1     memory op presented this cycle
//  req_ready    out  1     LSU can accept (state IDLE)
//  req_write    in   1     1=store, 0=load
//  req_funct3   in   3     RV32I funct3: 000 B,001 H,010 W,100 BU,101 HU
//  req_addr     in   32    effective address (ALU result)
//  req_wdata    in   32    rs2 store data
//  flush        in   1     squash current op (branch/trap)
//  done_valid   out  1     one-cycle pulse: op finished
//  done_rdata   out  32    extended load data (0 for stores)
//  done_error   out  1     misaligned access (MISALIGN_TRAP_EN only)
//  dmem_req     out  1     bus request, held until dmem_gnt
//  dmem_we      out  1     write enable
//  dmem_addr    out  32    word-aligned address {addr[31:2],2'b00}
//  dmem_be      out  4     byte enables
//  dmem_wdata   out  32    lane-replicated store data
//  dmem_gnt     in   1     request accepted this cycle
//  dmem_rvalid  in   1     read data valid
//  dmem_rdata   in   32    read word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; internal regs cleared.
//  FSM IDLE->REQ->(WAIT_R)->DONE->IDLE. Accept on req_valid&&req_ready; latch all req_* fields.
//  REQ: dmem_req=1, bus fields stable until dmem_gnt. Store+gnt->DONE; load+gnt->WAIT_R.
//  WAIT_R: dmem_rvalid sampled only here; capture lane, extend, ->DONE. rvalid earliest 1 cycle after gnt.
//  DONE: done_valid=1 for exactly one cycle, ->IDLE. No new accept in DONE.
//  Latency: accept T0, gnt T1, store done T2; load with rvalid T2 gives done T3.
//  Lanes: B be=4'b0001<<a[1:0], wdata={4{d[7:0]}}; H be=4'b0011<<{a[1],1'b0}, wdata={2{d[15:0]}}; W be=4'hF.
//  Loads select byte a[1:0] / half a[1]; B,H sign-extend; BU,HU zero-extend; dmem_be as for store.
//  funct3 011/110/111: treated as W.
//  flush in REQ before gnt: drop dmem_req next cycle, ->IDLE, no done. flush in WAIT_R or same
//   cycle as gnt: bus op completes, done_valid suppressed. flush in IDLE/DONE: no effect; flush
//   same cycle as accept: op not accepted.
//  reset_n low mid-op: immediate return to IDLE, outstanding bus op abandoned (dmem also reset).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with a[0]!=0 or W with a[1:0]!=0 issues no bus request;
//   REQ->DONE next cycle with done_error=1, done_rdata=0.
//  Undefined: done_error tied 0; misaligned H/W use a[1]/a[1:0]-masked lane (silent alignment).
// STRUCTURE
//  common package: mem_size_e (B,H,W,BU,HU from funct3), lsu_state_e, MEM_BE_* constants.
//  Sub-module lsu_lane_align (combinational): funct3+addr+data -> be/wdata, and rdata->extended load.
// TESTING
//  SW 0xDEADBEEF @0x100, gnt T1 -> be=F, addr 0x100, done_valid T2, rdata 0.
//  SB 0x...A5 @0x103 -> be=4'b1000, wdata 0xA5A5A5A5.
//  LB @0x102, rdata 0x00800000 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU @0x102 rdata 0x80010000 -> 0x00008001.
//  gnt withheld 5 cycles -> dmem_req/addr stable, req_ready=0 throughout; flush cycle 3 -> IDLE, no done.
//  LW, flush in WAIT_R, rvalid T4 -> no done_valid; next op accepted normally.
//  LH @0x101: LSU_MISALIGN_TRAP_EN -> no dmem_req, done_error=1; without macro -> be=4'b0011, normal load.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states,
// byte-enable patterns and small decode helpers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } lsu_state_e;

  localparam logic [3:0] MEM_BE_B = 4'b0001;
  localparam logic [3:0] MEM_BE_H = 4'b0011;
  localparam logic [3:0] MEM_BE_W = 4'b1111;

  // Unused funct3 encodings fall back to a full word.
  function automatic mem_size_e to_size(input logic [2:0] f3);
    mem_size_e s;
    unique case (f3)
      3'b000:  s = MEM_B;
      3'b001:  s = MEM_H;
      3'b100:  s = MEM_BU;
      3'b101:  s = MEM_HU;
      default: s = MEM_W;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input mem_size_e  s,
    input logic [1:0] off
  );
    logic m;
    unique case (s)
      MEM_H, MEM_HU: m = off[0];
      MEM_W:         m = |off;
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte enables and replicated store
// data on the way out, lane select plus extension on the way in.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_size_e         size,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   load_word,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   store_word,
  output logic [XLEN-1:0]   load_data
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    b_sel = load_word[8*offset +: 8];
    h_sel = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  // Misaligned halves/words are silently aligned by masking the offset.
  always_comb begin
    be         = MEM_BE_W;
    store_word = store_data;
    load_data  = load_word;
    unique case (size)
      MEM_B, MEM_BU: begin
        be         = MEM_BE_B << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = (size == MEM_B)
                   ? {{(XLEN-8){b_sel[7]}}, b_sel}
                   : {{(XLEN-8){1'b0}}, b_sel};
      end
      MEM_H, MEM_HU: begin
        be         = MEM_BE_H << {offset[1], 1'b0};
        store_word = {2{store_data[15:0]}};
        load_data  = (size == MEM_H)
                   ? {{(XLEN-16){h_sel[15]}}, h_sel}
                   : {{(XLEN-16){1'b0}}, h_sel};
      end
      default: begin
        be         = MEM_BE_W;
        store_word = store_data;
        load_data  = load_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit, one req/gnt/rvalid transaction in flight.
// LSU_MISALIGN_TRAP_EN: misaligned H/W report done_error instead of a bus op.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic                  flush,
  output logic                  done_valid,
  output logic [XLEN-1:0]       done_rdata,
  output logic                  done_error,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  op_write_q;
  mem_size_e             op_size_q;
  logic [ADDR_WIDTH-1:0] op_addr_q;
  logic [XLEN-1:0]       op_wdata_q;
  logic [XLEN-1:0]       rdata_q;
  logic                  drop_q;
  logic                  err_q;

  logic                  accept;
  logic                  capture;
  logic                  set_drop;
  logic                  set_err;
  logic                  mis;
  logic [3:0]            be;
  logic [XLEN-1:0]       store_word;
  logic [XLEN-1:0]       load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(op_size_q, op_addr_q[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .size       (op_size_q),
    .offset     (op_addr_q[1:0]),
    .store_data (op_wdata_q),
    .load_word  (dmem_rdata),
    .be         (be),
    .store_word (store_word),
    .load_data  (load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, handshake outputs and register-update strobes.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    dmem_req   = 1'b0;
    done_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    set_drop   = 1'b0;
    set_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        dmem_req = !mis;
        if (mis) begin
          set_err = !flush;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (dmem_gnt) begin
          set_drop = flush;
          state_d  = op_write_q ? S_DONE : S_WAIT_R;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_R: begin
        set_drop = flush;
        if (dmem_rvalid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = !drop_q;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Operation latch, load result and completion flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write_q <= 1'b0;
      op_size_q  <= MEM_B;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      rdata_q    <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_write_q <= req_write;
        op_size_q  <= to_size(req_funct3);
        op_addr_q  <= req_addr;
        op_wdata_q <= req_wdata;
        rdata_q    <= '0;
        drop_q     <= 1'b0;
        err_q      <= 1'b0;
      end
      if (set_drop) drop_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
      if (capture)  rdata_q <= load_data;
    end
  end

  // Bus fields are only non-zero while a request is presented.
  always_comb begin
    dmem_we    = dmem_req & op_write_q;
    dmem_addr  = dmem_req ? {op_addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    dmem_be    = dmem_req ? be : 4'b0000;
    dmem_wdata = dmem_we ? store_word : '0;
    done_rdata = done_valid ? rdata_q : '0;
    done_error = done_valid & err_q;
  end

endmodule
